// File: rtl/apb_watchdog.sv
// APB two-stage watchdog: the first expiry raises a bark interrupt, and a
// second expiry with no kick in between raises a sticky reset request (bite).
module apb_watchdog #(
    parameter int          APB_ADDR_WIDTH = 32,
    parameter logic [31:0] KICK_KEY       = 32'h5A5A_A5A5,
    parameter logic [31:0] RESET_LOAD     = 32'hFFFF_FFFF
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]               pwdata_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic                      irq_o,
    output logic                      rst_req_o
);

    // Register indices decoded from paddr_i[4:2]
    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_LOAD   = 3'd1;
    localparam logic [2:0] IDX_COUNT  = 3'd2;
    localparam logic [2:0] IDX_KICK   = 3'd3;
    localparam logic [2:0] IDX_STATUS = 3'd4;

    logic        r_en;
    logic        r_rstEn;
    logic [7:0]  r_presc;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic [7:0]  r_prescCnt;
    logic        r_bark;
    logic        r_badKey;
    logic        r_bitten;
    logic        r_rstReq;

    logic [2:0]  w_idx;
    logic        w_access;
    logic        w_unmapped;
    logic        w_error;
    logic        w_write;
    logic        w_ctrlWr;
    logic        w_loadWr;
    logic        w_kickWr;
    logic        w_statWr;
    logic        w_kickGood;
    logic        w_kickBad;
    logic        w_enRise;
    logic        w_tick;
    logic        w_expire;
    logic        w_barkSet;
    logic        w_bite;
    logic [31:0] w_rdata;
    logic        w_unusedAddr;

    assign w_idx      = paddr_i[4:2];
    assign w_access   = psel_i & penable_i;
    assign w_unmapped = w_idx[2] & (w_idx[1] | w_idx[0]);
    assign w_error    = w_access & (w_unmapped | (pwrite_i & (w_idx == IDX_COUNT)));
    assign w_write    = w_access & pwrite_i & ~w_error;

    // Only address bits [4:2] select a register; the rest are ignored.
    assign w_unusedAddr = ^{paddr_i[APB_ADDR_WIDTH-1:5], paddr_i[1:0]};

    assign w_ctrlWr   = w_write & (w_idx == IDX_CTRL);
    assign w_loadWr   = w_write & (w_idx == IDX_LOAD);
    assign w_kickWr   = w_write & (w_idx == IDX_KICK);
    assign w_statWr   = w_write & (w_idx == IDX_STATUS);
    assign w_kickGood = w_kickWr & (pwdata_i == KICK_KEY);
    assign w_kickBad  = w_kickWr & (pwdata_i != KICK_KEY);
    assign w_enRise   = w_ctrlWr & pwdata_i[0] & ~r_en;

    // A tick is the prescaler wrapping; after a bite the count stays parked
    // at zero until a good kick or a fresh enable restarts it. A kick in the
    // same cycle as an expiry cancels the expiry.
    assign w_tick    = r_en & ~r_bitten & (r_prescCnt == r_presc);
    assign w_expire  = w_tick & (r_count == 32'd0) & ~w_kickGood;
    assign w_barkSet = w_expire & ~r_bark;
    assign w_bite    = w_expire & r_bark;

    assign pready_o  = 1'b1;
    assign pslverr_o = w_error;
    assign irq_o     = r_bark | r_badKey;
    assign rst_req_o = r_rstReq;
    assign prdata_o  = w_rdata;

    // Read mux: only drives data during the access phase of a mapped register
    always_comb begin
        w_rdata = 32'd0;
        if (w_access) begin
            case (w_idx)
                IDX_CTRL:   w_rdata = {16'd0, r_presc, 6'd0, r_rstEn, r_en};
                IDX_LOAD:   w_rdata = r_load;
                IDX_COUNT:  w_rdata = r_count;
                IDX_STATUS: w_rdata = {30'd0, r_badKey, r_bark};
                default:    w_rdata = 32'd0;
            endcase
        end
    end

    // Register file, prescaler, down-counter and bark/bite state
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_en       <= 1'b0;
            r_rstEn    <= 1'b0;
            r_presc    <= 8'd0;
            r_load     <= RESET_LOAD;
            r_count    <= RESET_LOAD;
            r_prescCnt <= 8'd0;
            r_bark     <= 1'b0;
            r_badKey   <= 1'b0;
            r_bitten   <= 1'b0;
            r_rstReq   <= 1'b0;
        end else begin
            if (w_ctrlWr) begin
                r_en    <= pwdata_i[0];
                r_rstEn <= pwdata_i[1];
                r_presc <= pwdata_i[15:8];
            end
            if (w_loadWr) begin
                r_load <= pwdata_i;
            end

            if (w_enRise || w_kickGood || !r_en) begin
                r_prescCnt <= 8'd0;
            end else if (r_prescCnt == r_presc) begin
                r_prescCnt <= 8'd0;
            end else begin
                r_prescCnt <= r_prescCnt + 8'd1;
            end

            // Reloads use r_load as it was before any LOAD write this cycle
            if (w_enRise || w_kickGood) begin
                r_count <= r_load;
            end else if (w_tick) begin
                if (r_count != 32'd0) begin
                    r_count <= r_count - 32'd1;
                end else if (!r_bark) begin
                    r_count <= r_load;
                end
            end

            if (w_barkSet) begin
                r_bark <= 1'b1;
            end else if (w_kickGood || (w_statWr && pwdata_i[0])) begin
                r_bark <= 1'b0;
            end

            if (w_kickBad) begin
                r_badKey <= 1'b1;
            end else if (w_statWr && pwdata_i[1]) begin
                r_badKey <= 1'b0;
            end

            if (w_enRise || w_kickGood) begin
                r_bitten <= 1'b0;
            end else if (w_bite) begin
                r_bitten <= 1'b1;
            end

            if (w_bite && r_rstEn) begin
                r_rstReq <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_watchdog.sv
// Directed bench for apb_watchdog: reset values, bark/bite timing,
// prescaler, kick handling, error responses and the sticky reset request.
module tb_apb_watchdog;

    localparam logic [31:0] KEY = 32'h5A5A_A5A5;

    logic        clk_i;
    logic        rst_ni;
    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [31:0] paddr_i;
    logic [31:0] pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic        irq_o;
    logic        rst_req_o;

    int checks;
    int failures;

    logic [31:0] rd;
    logic        se;

    apb_watchdog #(
        .APB_ADDR_WIDTH(32),
        .KICK_KEY      (KEY),
        .RESET_LOAD    (32'hFFFF_FFFF)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .psel_i   (psel_i),
        .penable_i(penable_i),
        .pwrite_i (pwrite_i),
        .paddr_i  (paddr_i),
        .pwdata_i (pwdata_i),
        .prdata_o (prdata_o),
        .pready_o (pready_o),
        .pslverr_o(pslverr_o),
        .irq_o    (irq_o),
        .rst_req_o(rst_req_o)
    );

    // 10 ns clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Hard stop in case the directed sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    // One comparison: counts it, and reports tag/observed/expected on a miss
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One APB transfer, started 1 ns after a rising edge. Read data and error
    // are sampled mid access phase; the transfer commits on the second rising
    // edge and the task returns 1 ns after it.
    task automatic applyStimulus(input logic write, input logic [31:0] addr,
                                 input logic [31:0] data,
                                 output logic [31:0] rdata, output logic slverr);
        psel_i    = 1'b1;
        penable_i = 1'b0;
        pwrite_i  = write;
        paddr_i   = addr;
        pwdata_i  = data;
        @(posedge clk_i);
        #1;
        penable_i = 1'b1;
        #1;
        rdata  = prdata_o;
        slverr = pslverr_o;
        @(posedge clk_i);
        #1;
        psel_i    = 1'b0;
        penable_i = 1'b0;
        pwrite_i  = 1'b0;
    endtask

    // Directed sequence; addresses are index*4 (CTRL 0x0, LOAD 0x4, COUNT 0x8,
    // KICK 0xC, STATUS 0x10)
    initial begin
        checks    = 0;
        failures  = 0;
        rst_ni    = 1'b0;
        psel_i    = 1'b0;
        penable_i = 1'b0;
        pwrite_i  = 1'b0;
        paddr_i   = 32'd0;
        pwdata_i  = 32'd0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        checkOutput("rst_pready", {31'd0, pready_o}, 32'd1);
        checkOutput("rst_pslverr", {31'd0, pslverr_o}, 32'd0);
        checkOutput("rst_prdata_idle", prdata_o, 32'd0);
        checkOutput("rst_irq", {31'd0, irq_o}, 32'd0);
        checkOutput("rst_rstreq", {31'd0, rst_req_o}, 32'd0);
        applyStimulus(1'b0, 32'h0, 32'd0, rd, se);
        checkOutput("rst_ctrl", rd, 32'd0);
        applyStimulus(1'b0, 32'h4, 32'd0, rd, se);
        checkOutput("rst_load", rd, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 32'h8, 32'd0, rd, se);
        checkOutput("rst_count", rd, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 32'h10, 32'd0, rd, se);
        checkOutput("rst_status", rd, 32'd0);
        applyStimulus(1'b0, 32'hC, 32'd0, rd, se);
        checkOutput("kick_reads_zero", rd, 32'd0);

        // LOAD=10, PRESC=0, EN+RST_EN: bark 11 cycles after enable, bite 11 later
        applyStimulus(1'b1, 32'h4, 32'd10, rd, se);
        applyStimulus(1'b1, 32'h0, 32'h3, rd, se);
        repeat (10) @(posedge clk_i);
        #1;
        checkOutput("irq_before_bark", {31'd0, irq_o}, 32'd0);
        @(posedge clk_i);
        #1;
        checkOutput("irq_at_bark", {31'd0, irq_o}, 32'd1);
        repeat (10) @(posedge clk_i);
        #1;
        checkOutput("rstreq_before_bite", {31'd0, rst_req_o}, 32'd0);
        @(posedge clk_i);
        #1;
        checkOutput("rstreq_at_bite", {31'd0, rst_req_o}, 32'd1);

        // Bite is sticky across register writes and a good kick
        applyStimulus(1'b1, 32'h0, 32'd0, rd, se);
        checkOutput("rstreq_after_ctrl0", {31'd0, rst_req_o}, 32'd1);
        applyStimulus(1'b0, 32'h8, 32'd0, rd, se);
        checkOutput("count_held_after_bite", rd, 32'd0);
        applyStimulus(1'b1, 32'hC, KEY, rd, se);
        checkOutput("rstreq_after_kick", {31'd0, rst_req_o}, 32'd1);
        applyStimulus(1'b0, 32'h8, 32'd0, rd, se);
        checkOutput("count_reload_by_kick", rd, 32'd10);

        // A single reset edge clears everything
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        checkOutput("rstreq_cleared_by_reset", {31'd0, rst_req_o}, 32'd0);
        checkOutput("irq_cleared_by_reset", {31'd0, irq_o}, 32'd0);
        applyStimulus(1'b0, 32'h4, 32'd0, rd, se);
        checkOutput("load_after_reset", rd, 32'hFFFF_FFFF);

        // Prescaler: LOAD=4, PRESC=3, one decrement every 4 cycles
        applyStimulus(1'b1, 32'h4, 32'd4, rd, se);
        applyStimulus(1'b1, 32'h0, 32'hABCD_0301, rd, se);
        repeat (8) @(posedge clk_i);
        #1;
        applyStimulus(1'b0, 32'h8, 32'd0, rd, se);
        checkOutput("presc_count_9cyc", rd, 32'd2);
        applyStimulus(1'b0, 32'h0, 32'd0, rd, se);
        checkOutput("ctrl_masked_read", rd, 32'h0000_0301);
        applyStimulus(1'b1, 32'h0, 32'd0, rd, se);

        // Bark with LOAD=2 lands 3 cycles after enable
        applyStimulus(1'b1, 32'h4, 32'd2, rd, se);
        applyStimulus(1'b1, 32'h0, 32'h1, rd, se);
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("irq_before_bark2", {31'd0, irq_o}, 32'd0);
        @(posedge clk_i);
        #1;
        checkOutput("irq_bark2", {31'd0, irq_o}, 32'd1);
        applyStimulus(1'b1, 32'h0, 32'd0, rd, se);
        applyStimulus(1'b0, 32'h10, 32'd0, rd, se);
        checkOutput("status_bark", rd, 32'h1);

        // Good kick clears the bark and reloads; a bad key sets BADKEY
        applyStimulus(1'b1, 32'hC, KEY, rd, se);
        checkOutput("irq_after_good_kick", {31'd0, irq_o}, 32'd0);
        applyStimulus(1'b0, 32'h10, 32'd0, rd, se);
        checkOutput("status_after_good_kick", rd, 32'd0);
        applyStimulus(1'b0, 32'h8, 32'd0, rd, se);
        checkOutput("count_after_good_kick", rd, 32'd2);
        applyStimulus(1'b1, 32'hC, 32'h1234, rd, se);
        checkOutput("irq_after_bad_kick", {31'd0, irq_o}, 32'd1);
        applyStimulus(1'b0, 32'h10, 32'd0, rd, se);
        checkOutput("status_badkey", rd, 32'h2);
        applyStimulus(1'b0, 32'h8, 32'd0, rd, se);
        checkOutput("count_untouched_bad_kick", rd, 32'd2);
        applyStimulus(1'b1, 32'h10, 32'h2, rd, se);
        checkOutput("irq_after_w1c", {31'd0, irq_o}, 32'd0);
        applyStimulus(1'b0, 32'h10, 32'd0, rd, se);
        checkOutput("status_after_w1c", rd, 32'd0);

        // LOAD=0, PRESC=0, EN only: the enable and a kick are back-to-back
        // access cycles, so the kick lands on the very first expiry tick
        applyStimulus(1'b1, 32'h4, 32'd0, rd, se);
        psel_i    = 1'b1;
        penable_i = 1'b0;
        pwrite_i  = 1'b1;
        paddr_i   = 32'h0;
        pwdata_i  = 32'h1;
        @(posedge clk_i);
        #1;
        penable_i = 1'b1;
        @(posedge clk_i);
        #1;
        paddr_i  = 32'hC;
        pwdata_i = KEY;
        @(posedge clk_i);
        #1;
        psel_i    = 1'b0;
        penable_i = 1'b0;
        pwrite_i  = 1'b0;
        checkOutput("no_bark_kick_at_expiry", {31'd0, irq_o}, 32'd0);
        @(posedge clk_i);
        #1;
        checkOutput("bark_next_tick_load0", {31'd0, irq_o}, 32'd1);

        // Bite with RST_EN=0 parks the count at zero without a reset request
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("no_rstreq_rsten0", {31'd0, rst_req_o}, 32'd0);
        applyStimulus(1'b0, 32'h8, 32'd0, rd, se);
        checkOutput("count_zero_after_bite", rd, 32'd0);

        // A good kick resumes counting, so LOAD=0 barks again one tick later
        applyStimulus(1'b1, 32'hC, KEY, rd, se);
        checkOutput("irq_cleared_resume", {31'd0, irq_o}, 32'd0);
        @(posedge clk_i);
        #1;
        checkOutput("bark_after_resume", {31'd0, irq_o}, 32'd1);
        applyStimulus(1'b1, 32'h0, 32'd0, rd, se);

        // Error responses: unmapped index and a write to COUNT
        applyStimulus(1'b0, 32'h18, 32'd0, rd, se);
        checkOutput("slverr_read_idx6", {31'd0, se}, 32'd1);
        checkOutput("rdata_idx6", rd, 32'd0);
        applyStimulus(1'b1, 32'h8, 32'h55, rd, se);
        checkOutput("slverr_write_count", {31'd0, se}, 32'd1);
        applyStimulus(1'b1, 32'h1C, 32'h77, rd, se);
        checkOutput("slverr_write_idx7", {31'd0, se}, 32'd1);
        applyStimulus(1'b0, 32'h8, 32'd0, rd, se);
        checkOutput("slverr_read_count_ok", {31'd0, se}, 32'd0);
        checkOutput("count_unchanged_by_err", rd, 32'd0);
        applyStimulus(1'b0, 32'h4, 32'd0, rd, se);
        checkOutput("load_unchanged_by_err", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
